id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the 64-bit ALU: captures decoded ops and drives ALU Bus_A/Bus_B/CONTROL.

---
 rtl/id_ex_operand_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register that feeds the 64-bit ALU. It resolves RAW hazards
// by forwarding from EX, MEM and WB, and inserts a single bubble on a
// load-use hazard. It obeys downstream hold and branch flush, and keeps a
// saturating count of the load-use bubbles it has inserted.
module id_ex_operand_stage #(
  parameter int DW    = 64,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  // decode slot
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rn,
  input  logic [RW-1:0]    id_rm,
  input  logic [RW-1:0]    id_rd,
  input  logic [DW-1:0]    id_rn_data,
  input  logic [DW-1:0]    id_rm_data,
  input  logic [DW-1:0]    id_imm,
  input  logic             id_use_imm,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_is_load,
  input  logic             id_reg_write,
  // results from downstream stages, used for forwarding
  input  logic [DW-1:0]    alu_out,
  input  logic [RW-1:0]    mem_rd,
  input  logic             mem_reg_write,
  input  logic [DW-1:0]    mem_result,
  input  logic [RW-1:0]    wb_rd,
  input  logic             wb_reg_write,
  input  logic [DW-1:0]    wb_result,
  // pipeline control
  input  logic             ex_hold,
  input  logic             flush,
  // towards the ALU and the MEM stage
  output logic             ex_valid,
  output logic [DW-1:0]    ex_bus_a,
  output logic [DW-1:0]    ex_bus_b,
  output logic [3:0]       ex_alu_ctrl,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_is_load,
  output logic             ex_reg_write,
  output logic [DW-1:0]    ex_store_data,
  output logic             id_stall,
  output logic [CNT_W-1:0] stall_count
);

  // Register 31 is the zero register: it reads as zero, is never forwarded,
  // and never creates a hazard.
  localparam logic [RW-1:0] XZR = '1;

  // Everything the EX stage carries, kept together so that the hold, bubble
  // and flush cases stay readable.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] bus_a;
    logic [DW-1:0] bus_b;
    logic [3:0]    alu_ctrl;
    logic [RW-1:0] rd;
    logic          is_load;
    logic          reg_write;
    logic [DW-1:0] store_data;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             ex_fwd_en;
  logic             luse;
  logic [DW-1:0]    fwd_rn, fwd_rm;

  // A load result is not ready in EX. That case is handled by the load-use
  // bubble, so EX forwards only non-load writers.
  assign ex_fwd_en = ex_q.valid & ex_q.reg_write & ~ex_q.is_load;

  // Forwarding priority: the youngest producer wins. The zero register
  // overrides every producer.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src,
                                        input logic [DW-1:0] rf_data);
    logic [DW-1:0] val;
    if (src == XZR)                            val = '0;
    else if (ex_fwd_en && ex_q.rd == src)      val = alu_out;
    else if (mem_reg_write && mem_rd == src)   val = mem_result;
    else if (wb_reg_write && wb_rd == src)     val = wb_result;
    else                                       val = rf_data;
    return val;
  endfunction

  // Operand selection for both sources in the decode cycle.
  always_comb begin
    fwd_rn = fwd(id_rn, id_rn_data);
    fwd_rm = fwd(id_rm, id_rm_data);
  end

  // rm is a hazard source only when the instruction reads it as Bus_B, which
  // means it does not use the immediate.
  assign luse = id_valid & ex_q.valid & ex_q.is_load & ex_q.reg_write &
                (ex_q.rd != XZR) &
                ((ex_q.rd == id_rn) | ((ex_q.rd == id_rm) & ~id_use_imm));

  // Reset and flush both release the upstream stage.
  assign id_stall = ~reset & ~flush & (ex_hold | luse);

  // Next state: flush beats hold, hold beats the bubble, and the bubble
  // beats a normal capture.
  always_comb begin
    // NOTE: Default every output of this block to its current value first.
    // Otherwise a path that leaves a field unassigned would infer a latch.
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      // The bubble invariant still holds: an invalid slot never writes.
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.is_load   = 1'b0;
    end else if (ex_hold) begin
      // Freeze. Any pending load-use is re-evaluated after the hold lifts.
    end else if (luse) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.is_load   = 1'b0;
      if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid      = id_valid;
      ex_d.bus_a      = fwd_rn;
      ex_d.bus_b      = id_use_imm ? id_imm : fwd_rm;
      ex_d.alu_ctrl   = id_alu_ctrl;
      ex_d.rd         = id_rd;
      ex_d.is_load    = id_valid & id_is_load;
      ex_d.reg_write  = id_valid & id_reg_write;
      ex_d.store_data = fwd_rm;
    end
  end

  // Pipeline register and stall counter, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: Sequential state uses non-blocking assignments. Every register
    // then samples its pre-edge value, whatever the statement order.
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_bus_a      = ex_q.bus_a;
  assign ex_bus_b      = ex_q.bus_b;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_rd         = ex_q.rd;
  assign ex_is_load    = ex_q.is_load;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_store_data = ex_q.store_data;
  assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage. It checks forwarding priority, the
// zero register, the load-use bubble, hold/flush priority, counter
// saturation and reset.
module tb_id_ex_operand_stage;

  localparam int DW    = 64;
  localparam int RW    = 5;
  // A narrow counter makes the saturation point reachable in a short run.
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [RW-1:0]    id_rn, id_rm, id_rd;
  logic [DW-1:0]    id_rn_data, id_rm_data, id_imm;
  logic             id_use_imm;
  logic [3:0]       id_alu_ctrl;
  logic             id_is_load, id_reg_write;
  logic [DW-1:0]    alu_out;
  logic [RW-1:0]    mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  logic [DW-1:0]    mem_result, wb_result;
  logic             ex_hold, flush;
  logic             ex_valid;
  logic [DW-1:0]    ex_bus_a, ex_bus_b, ex_store_data;
  logic [3:0]       ex_alu_ctrl;
  logic [RW-1:0]    ex_rd;
  logic             ex_is_load, ex_reg_write;
  logic             id_stall;
  logic [CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_is_load(id_is_load), .id_reg_write(id_reg_write),
    .alu_out(alu_out),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_hold(ex_hold), .flush(flush),
    .ex_valid(ex_valid), .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data),
    .id_stall(id_stall), .stall_count(stall_count)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set every input to a quiet value. reset is left unchanged.
  task automatic drive_idle();
    id_valid = 0; id_rn = '0; id_rm = '0; id_rd = '0;
    id_rn_data = '0; id_rm_data = '0; id_imm = '0; id_use_imm = 0;
    id_alu_ctrl = 4'b0000; id_is_load = 0; id_reg_write = 0;
    alu_out = '0; mem_rd = '0; mem_reg_write = 0; mem_result = '0;
    wb_rd = '0; wb_reg_write = 0; wb_result = '0;
    ex_hold = 0; flush = 0;
  endtask

  // Decode holds LDUR X<rd>, [X2, #imm].
  task automatic drive_load(input logic [RW-1:0] rd, input logic [DW-1:0] base,
                            input logic [DW-1:0] imm);
    drive_idle();
    id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = rd;
    id_rn = 5'd2; id_rn_data = base; id_use_imm = 1; id_imm = imm;
    id_alu_ctrl = 4'b0010;
  endtask

  // Decode holds ADD X2, X1, X3, which depends on X1.
  task automatic drive_dep_add();
    drive_idle();
    id_valid = 1; id_reg_write = 1; id_rd = 5'd2;
    id_rn = 5'd1; id_rm = 5'd3; id_rn_data = 64'hBAD; id_rm_data = 64'd7;
    id_alu_ctrl = 4'b0010;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    id_valid = 1; id_rn = 5'd2; id_rm = 5'd3; id_rd = 5'd1;
    id_rn_data = 64'h55; id_rm_data = 64'h66; id_reg_write = 1;
    id_alu_ctrl = 4'b1100; ex_hold = 1;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL reset_id_stall got %b exp 0", id_stall); end
    tick(); tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
    n_checks++; if (ex_bus_a !== 64'd0 || ex_bus_b !== 64'd0 || ex_store_data !== 64'd0) begin n_errors++; $display("FAIL reset_buses got %h %h %h exp 0", ex_bus_a, ex_bus_b, ex_store_data); end
    n_checks++; if (ex_alu_ctrl !== 4'b0000 || ex_rd !== 5'd0) begin n_errors++; $display("FAIL reset_ctrl_rd got %b %0d exp 0 0", ex_alu_ctrl, ex_rd); end
    n_checks++; if (ex_is_load !== 1'b0 || ex_reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_flags got %b %b exp 0 0", ex_is_load, ex_reg_write); end
    n_checks++; if (stall_count !== 8'd0) begin n_errors++; $display("FAIL reset_stall_count got %0d exp 0", stall_count); end
    reset = 0;
  endtask

  task automatic test_basic_add();
    // ADD X1, X2, X3 with X2 = 5 and X3 = 7, no hazards
    drive_idle();
    id_valid = 1; id_rd = 5'd1; id_rn = 5'd2; id_rm = 5'd3;
    id_rn_data = 64'd5; id_rm_data = 64'd7; id_alu_ctrl = 4'b0010; id_reg_write = 1;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL add_id_stall got %b exp 0", id_stall); end
    tick();
    n_checks++; if (ex_bus_a !== 64'd5) begin n_errors++; $display("FAIL add_bus_a got %h exp 5", ex_bus_a); end
    n_checks++; if (ex_bus_b !== 64'd7) begin n_errors++; $display("FAIL add_bus_b got %h exp 7", ex_bus_b); end
    n_checks++; if (ex_alu_ctrl !== 4'b0010) begin n_errors++; $display("FAIL add_ctrl got %b exp 0010", ex_alu_ctrl); end
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_reg_write !== 1'b1 || ex_is_load !== 1'b0) begin n_errors++; $display("FAIL add_ctl_fields got v%b rd%0d rw%b ld%b exp v1 rd1 rw1 ld0", ex_valid, ex_rd, ex_reg_write, ex_is_load); end
    n_checks++; if (ex_store_data !== 64'd7) begin n_errors++; $display("FAIL add_store got %h exp 7", ex_store_data); end
  endtask

  task automatic test_back_to_back();
    // SUB X4, X1, X1 right behind ADD X1: EX must beat MEM and WB
    drive_idle();
    id_valid = 1; id_rd = 5'd4; id_rn = 5'd1; id_rm = 5'd1; id_reg_write = 1;
    id_rn_data = 64'h1111; id_rm_data = 64'h2222; id_alu_ctrl = 4'b0110;
    alu_out = 64'd12;
    mem_rd = 5'd1; mem_reg_write = 1; mem_result = 64'd99;
    wb_rd = 5'd1; wb_reg_write = 1; wb_result = 64'd99;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL b2b_id_stall got %b exp 0", id_stall); end
    tick();
    n_checks++; if (ex_bus_a !== 64'd12) begin n_errors++; $display("FAIL b2b_bus_a got %h exp c", ex_bus_a); end
    n_checks++; if (ex_bus_b !== 64'd12) begin n_errors++; $display("FAIL b2b_bus_b got %h exp c", ex_bus_b); end
    n_checks++; if (ex_alu_ctrl !== 4'b0110) begin n_errors++; $display("FAIL b2b_ctrl got %b exp 0110", ex_alu_ctrl); end
  endtask

  task automatic test_forward_priority();
    // ADD X5, X1, #0x40 with rm = X4. EX holds SUB X4, MEM and WB both write X1.
    drive_idle();
    id_valid = 1; id_rd = 5'd5; id_rn = 5'd1; id_rm = 5'd4; id_reg_write = 1;
    id_rn_data = 64'hAAAA; id_rm_data = 64'hBBBB; id_use_imm = 1; id_imm = 64'h40;
    id_alu_ctrl = 4'b0010; alu_out = 64'h30;
    mem_rd = 5'd1; mem_reg_write = 1; mem_result = 64'd99;
    wb_rd = 5'd1; wb_reg_write = 1; wb_result = 64'd55;
    tick();
    n_checks++; if (ex_bus_a !== 64'd99) begin n_errors++; $display("FAIL fwd_mem_over_wb got %h exp 63", ex_bus_a); end
    n_checks++; if (ex_bus_b !== 64'h40) begin n_errors++; $display("FAIL fwd_imm_bus_b got %h exp 40", ex_bus_b); end
    n_checks++; if (ex_store_data !== 64'h30) begin n_errors++; $display("FAIL fwd_store_from_ex got %h exp 30", ex_store_data); end
    // X7 is matched by MEM, but its write enable is off, so WB supplies it.
    drive_idle();
    id_valid = 1; id_rd = 5'd6; id_rn = 5'd7; id_rm = 5'd8; id_reg_write = 1;
    id_rn_data = 64'h1; id_rm_data = 64'h88; id_alu_ctrl = 4'b0001; alu_out = 64'h5;
    mem_rd = 5'd7; mem_reg_write = 0; mem_result = 64'h11;
    wb_rd = 5'd7; wb_reg_write = 1; wb_result = 64'h77;
    tick();
    n_checks++; if (ex_bus_a !== 64'h77) begin n_errors++; $display("FAIL fwd_wb got %h exp 77", ex_bus_a); end
    n_checks++; if (ex_bus_b !== 64'h88) begin n_errors++; $display("FAIL fwd_regfile got %h exp 88", ex_bus_b); end
  endtask

  task automatic test_load_use();
    drive_load(5'd1, 64'h100, 64'd8);
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_rd !== 5'd1) begin n_errors++; $display("FAIL lu_load_in_ex got v%b ld%b rd%0d exp v1 ld1 rd1", ex_valid, ex_is_load, ex_rd); end
    n_checks++; if (ex_bus_a !== 64'h100 || ex_bus_b !== 64'd8) begin n_errors++; $display("FAIL lu_load_buses got %h %h exp 100 8", ex_bus_a, ex_bus_b); end
    drive_dep_add();
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_errors++; $display("FAIL lu_id_stall got %b exp 1", id_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_is_load !== 1'b0) begin n_errors++; $display("FAIL lu_bubble got v%b rw%b ld%b exp 0 0 0", ex_valid, ex_reg_write, ex_is_load); end
    n_checks++; if (stall_count !== 8'd1) begin n_errors++; $display("FAIL lu_count got %0d exp 1", stall_count); end
    // The load is now in MEM, so its data is forwarded from there.
    mem_rd = 5'd1; mem_reg_write = 1; mem_result = 64'hCAFE;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL lu_release got %b exp 0", id_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_bus_a !== 64'hCAFE || ex_bus_b !== 64'd7) begin n_errors++; $display("FAIL lu_fwd_mem got v%b %h %h exp v1 cafe 7", ex_valid, ex_bus_a, ex_bus_b); end
    n_checks++; if (stall_count !== 8'd1) begin n_errors++; $display("FAIL lu_single_bubble got %0d exp 1", stall_count); end
  endtask

  task automatic test_xzr();
    drive_idle();
    id_valid = 1; id_rn = 5'd31; id_rm = 5'd31; id_rd = 5'd9; id_reg_write = 1;
    id_rn_data = 64'h123; id_rm_data = 64'h456; id_alu_ctrl = 4'b0010;
    mem_rd = 5'd31; mem_reg_write = 1; mem_result = 64'hDEAD;
    wb_rd = 5'd31; wb_reg_write = 1; wb_result = 64'hBEEF;
    tick();
    n_checks++; if (ex_bus_a !== 64'd0) begin n_errors++; $display("FAIL xzr_bus_a got %h exp 0", ex_bus_a); end
    n_checks++; if (ex_bus_b !== 64'd0) begin n_errors++; $display("FAIL xzr_bus_b got %h exp 0", ex_bus_b); end
    drive_load(5'd31, 64'h10, 64'd0);
    tick();
    drive_idle();
    id_valid = 1; id_rn = 5'd31; id_rm = 5'd31; id_rd = 5'd3; id_reg_write = 1;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL xzr_no_stall got %b exp 0", id_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || stall_count !== 8'd1) begin n_errors++; $display("FAIL xzr_no_bubble got v%b cnt%0d exp v1 cnt1", ex_valid, stall_count); end
  endtask

  task automatic test_hold_flush();
    drive_load(5'd1, 64'h200, 64'h10);
    tick();
    drive_dep_add();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (id_stall !== 1'b1) begin n_errors++; $display("FAIL hold_id_stall[%0d] got %b exp 1", i, id_stall); end
      tick();
      n_checks++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_bus_a !== 64'h200 || ex_bus_b !== 64'h10 || stall_count !== 8'd1) begin n_errors++; $display("FAIL hold_frozen[%0d] got v%b ld%b %h %h cnt%0d exp v1 ld1 200 10 cnt1", i, ex_valid, ex_is_load, ex_bus_a, ex_bus_b, stall_count); end
    end
    flush = 1;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL flush_id_stall got %b exp 0", id_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || stall_count !== 8'd1) begin n_errors++; $display("FAIL flush_ex_valid got v%b cnt%0d exp v0 cnt1", ex_valid, stall_count); end
  endtask

  // One load followed by a dependent ADD costs exactly one bubble.
  task automatic luse_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      drive_load(5'd1, 64'h8, 64'd0);
      tick();
      drive_dep_add();
      tick();
    end
  endtask

  task automatic test_saturation();
    luse_pairs(253);
    n_checks++; if (stall_count !== 8'hFE) begin n_errors++; $display("FAIL sat_below got %h exp fe", stall_count); end
    luse_pairs(1);
    n_checks++; if (stall_count !== 8'hFF) begin n_errors++; $display("FAIL sat_reach got %h exp ff", stall_count); end
    luse_pairs(3);
    n_checks++; if (stall_count !== 8'hFF) begin n_errors++; $display("FAIL sat_hold got %h exp ff", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    drive_load(5'd1, 64'h300, 64'h4);
    tick();
    drive_dep_add();
    reset = 1;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_errors++; $display("FAIL rst_mid_id_stall got %b exp 0", id_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_bus_a !== 64'd0 || ex_bus_b !== 64'd0 || ex_rd !== 5'd0 || ex_is_load !== 1'b0 || ex_alu_ctrl !== 4'b0000) begin n_errors++; $display("FAIL rst_mid_regs got v%b %h %h rd%0d ld%b c%b exp all 0", ex_valid, ex_bus_a, ex_bus_b, ex_rd, ex_is_load, ex_alu_ctrl); end
    n_checks++; if (stall_count !== 8'd0) begin n_errors++; $display("FAIL rst_mid_count got %0d exp 0", stall_count); end
    reset = 0;
    drive_idle();
    tick();
    n_checks++; if (ex_valid !== 1'b0 || stall_count !== 8'd0) begin n_errors++; $display("FAIL rst_after got v%b cnt%0d exp v0 cnt0", ex_valid, stall_count); end
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_forward_priority();
    test_load_use();
    test_xzr();
    test_hold_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
